// File: rtl/fifo_thresh.sv
// fifo_thresh: synchronous FIFO with fill count, programmable almost-full/almost-empty thresholds and sticky error flags
//   params : depth (entries, power of two >= 2), width (data bits), AF_THRESH, AE_THRESH
//   clk, rst (async, active-high)
//   wr_en/din write side, rd_en/dout/dout_valid read side
//   empty, full, almost_full, almost_empty, count : fill status, decoded from registered count
//   overflow, underflow : sticky errors, cleared by err_clr (a same-edge set wins)
//   `FIFO_FWFT_EN defined : first-word-fall-through read; undefined : registered 1-cycle read
module fifo_thresh #(
  parameter int depth     = 8,
  parameter int width     = 16,
  parameter int AF_THRESH = depth - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [width-1:0]         din,
  input  logic                     rd_en,
  output logic [width-1:0]         dout,
  output logic                     dout_valid,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(depth):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     err_clr
);
  localparam int aw = $clog2(depth);
  localparam int cw = aw + 1;
  logic [width-1:0] mem [depth];
  logic [aw-1:0]    wr_ptr, rd_ptr;
  logic             wr_ok, rd_ok;
  assign empty        = count == '0;
  assign full         = count == cw'(depth);
  assign almost_full  = count >= cw'(AF_THRESH);
  assign almost_empty = count <= cw'(AE_THRESH);
  assign wr_ok        = wr_en && !full;
  assign rd_ok        = rd_en && !empty;
  // rst gate keeps a clock edge during reset from landing a write
  always_ff @(posedge clk)
    if (wr_ok && !rst) mem[wr_ptr] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr + aw'(wr_ok);
      rd_ptr    <= rd_ptr + aw'(rd_ok);
      count     <= count + cw'(wr_ok) - cw'(rd_ok);
      overflow  <= (wr_en && full) || (overflow && !err_clr);
      underflow <= (rd_en && empty) || (underflow && !err_clr);
    end
`ifdef FIFO_FWFT_EN
  assign dout       = empty ? '0 : mem[rd_ptr];
  assign dout_valid = !empty;
`else
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout       <= rd_ok ? mem[rd_ptr] : dout;
      dout_valid <= rd_ok;
    end
`endif
endmodule

// File: tb/tb_fifo_thresh.sv
// tb_fifo_thresh: randomized and directed checks of fifo_thresh against a queue-based reference model
module tb_fifo_thresh;
  logic        clk = 0, rst = 0, wr_en = 0, rd_en = 0, err_clr = 0;
  logic [15:0] din = 0, dout;
  logic        dout_valid, empty, full, almost_full, almost_empty, overflow, underflow;
  logic [3:0]  count;
  int          n_chk = 0, n_fail = 0;
  logic [15:0] q[$];
  logic        m_ovf = 0, m_udf = 0, m_dv = 0;
  logic [15:0] m_dout = 0;

  fifo_thresh #(.depth(8), .width(16), .AF_THRESH(6), .AE_THRESH(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout), .dout_valid(dout_valid), .empty(empty), .full(full),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    int c = q.size();
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".empty"}, 32'(empty), 32'(c == 0));
    chk({tag, ".full"}, 32'(full), 32'(c == 8));
    chk({tag, ".almost_full"}, 32'(almost_full), 32'(c >= 6));
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(c <= 2));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".underflow"}, 32'(underflow), 32'(m_udf));
`ifdef FIFO_FWFT_EN
    chk({tag, ".dout_valid"}, 32'(dout_valid), 32'(c != 0));
    chk({tag, ".dout"}, 32'(dout), c != 0 ? 32'(q[0]) : 32'd0);
`else
    chk({tag, ".dout_valid"}, 32'(dout_valid), 32'(m_dv));
    chk({tag, ".dout"}, 32'(dout), 32'(m_dout));
`endif
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_udf = 0; m_dv = 0; m_dout = 0;
  endtask

  // called at a negedge: drive, take one rising edge, advance model, check at the next negedge
  task automatic step(input string tag, input logic we, input logic re, input logic ec, input logic [15:0] d);
    bit f = q.size() == 8;
    bit e = q.size() == 0;
    wr_en = we; rd_en = re; err_clr = ec; din = d;
    @(posedge clk);
    m_dv = re && !e;
    if (re && !e) m_dout = q.pop_front();
    if (we && !f) q.push_back(d);
    m_ovf = (we && f) || (m_ovf && !ec);
    m_udf = (re && e) || (m_udf && !ec);
    @(negedge clk);
    wr_en = 0; rd_en = 0; err_clr = 0;
    check_all(tag);
  endtask

  initial begin
    #1 rst = 1;
    #2 check_all("reset");
    @(negedge clk) rst = 0;
    check_all("post_reset");
    step("w1111", 1, 0, 0, 16'h1111);
    step("w2222", 1, 0, 0, 16'h2222);
    step("rd1", 0, 1, 0, 0);
    step("rd2", 0, 1, 0, 0);
    step("idle", 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) step("fill", 1, 0, 0, 16'(16'hA000 + i));
    step("full_both", 1, 1, 0, 16'hBEEF);
    step("refill", 1, 0, 0, 16'hC0DE);
    for (int i = 0; i < 8; i++) step("drain", 0, 1, 0, 0);
    step("empty_both", 1, 1, 0, 16'h5A5A);
    step("pop_one", 0, 1, 0, 0);
    for (int i = 0; i < 20; i++) step("wrap", 1, q.size() >= 2, 0, 16'(i));
    while (q.size() != 0) step("wrap_drain", 0, 1, 0, 0);
    step("err_clr", 0, 0, 1, 0);
    step("clr_vs_set", 0, 1, 1, 0);
    step("err_clr2", 0, 0, 1, 0);
    for (int i = 0; i < 400; i++)
      step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 15) == 0, 16'($urandom));
    while (q.size() > 0) step("pre_ar", 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step("ar_fill", 1, 0, 0, 16'(16'h7000 + i));
    step("ar_ovf_none", 0, 0, 0, 0);
    #2 rst = 1;
    #1 model_reset();
    check_all("async_rst");
    @(negedge clk) rst = 0;
    check_all("after_ar");
    step("fwft_w", 1, 0, 0, 16'hABCD);
    step("fwft_idle", 0, 0, 0, 0);
    step("fwft_pop", 0, 1, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_thresh.md
# fifo_thresh

Parametrised synchronous FIFO, successor to the team's fixed-flag FIFO. Adds a fill-level count, programmable almost-full and almost-empty thresholds, and sticky overflow/underflow error flags. A compile-time first-word-fall-through read mode is also available. It sits between a single-clock producer and consumer as the standard elastic buffer for datapath blocks.

## Interface
- `depth`, 8: number of entries; power of two, ≥2.
- `width`, 16: data bits per entry.
- `AF_THRESH`, depth-2: `almost_full` asserts when count ≥ this; range 1..depth.
- `AE_THRESH`, 2: `almost_empty` asserts when count ≤ this; range 0..depth-1.

- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `wr_en`, input, 1: write request.
- `din`, input, width: write data.
- `rd_en`, input, 1: read request.
- `dout`, output, width: read data.
- `dout_valid`, output, 1: `dout` holds valid read data.
- `empty`, output, 1: count == 0.
- `full`, output, 1: count == depth.
- `almost_full`, output, 1: count ≥ AF_THRESH.
- `almost_empty`, output, 1: count ≤ AE_THRESH.
- `count`, output, $clog2(depth)+1: current number of stored entries.
- `overflow`, output, 1: sticky; a write was attempted while full.
- `underflow`, output, 1: sticky; a read was attempted while empty.
- `err_clr`, input, 1: clears `overflow` and `underflow`.

## Operation
- Storage is a `depth`×`width` array. Write and read pointers are $clog2(depth) bits wide and wrap naturally from depth-1 to 0. The memory array is not reset.
- A write is accepted iff `wr_en && !full`. An accepted write stores `din` at wr_ptr and then increments wr_ptr.
- A read is accepted iff `rd_en && !empty`. An accepted read increments rd_ptr.
- `count` is a register:
  - +1 on a write-only cycle.
  - −1 on a read-only cycle.
  - Unchanged when both or neither are accepted.
- All flags decode combinationally from the registered `count`, so they are glitch-free and change only after a clock edge.
- Simultaneous request when full: the read is accepted and the write is rejected; `overflow` sets and count goes depth→depth-1.
- Simultaneous request when empty: the write is accepted and the read is rejected; `underflow` sets and count goes 0→1.
- Simultaneous request at 0 < count < depth: both are accepted and count is unchanged.
- `overflow` sets on any edge where `wr_en && full`. `underflow` sets on any edge where `rd_en && empty`.
- `err_clr` clears both sticky flags. If a set condition and `err_clr` occur on the same edge, set wins.
- Reset values: pointers 0, count 0, `empty`=1, `almost_empty`=1, `full`=0, `almost_full`=0, `overflow`=0, `underflow`=0, `dout`=0, `dout_valid`=0.
- Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge. No write or read is accepted while `rst` is high.

## Timing
- Write to flag latency: 1 cycle. For example, a write accepted at edge N clears `empty` after edge N.
- Standard mode read latency: 1 cycle.
  - `dout` registers mem[rd_ptr] on the edge that accepts the read.
  - `dout_valid` is high for exactly the following cycle.
  - `dout` holds its last value when no read is accepted.
- Back-to-back reads yield one word per cycle. Full throughput is one write plus one read per cycle.

## Configuration
- Macro `FIFO_FWFT_EN`, defined: first-word-fall-through mode.
  - `dout` = mem[rd_ptr] combinationally whenever `!empty`, and `dout_valid` = `!empty`.
  - `rd_en` acknowledges (pops) the presented word.
  - A word written into an empty FIFO appears on `dout` the cycle after its write edge.
  - `dout` is 0 while empty and during reset.
- Macro `FIFO_FWFT_EN`, undefined: standard registered-read behaviour as in Timing.
- Flags, count, and the error logic are identical in both modes.

## Test plan
All scenarios use depth=8, width=16, AF_THRESH=6, AE_THRESH=2.
- Reset, then write 0x1111, 0x2222, then read twice (standard mode) -> `dout`=0x1111 with `dout_valid` high the cycle after the first read edge, then 0x2222; `empty` returns to 1; count goes 0,1,2,1,0.
- Write 8 consecutive words -> `almost_empty` drops when count=3; `almost_full` rises when count=6; `full`=1 when count=8; a 9th `wr_en` sets `overflow` and leaves count=8 and the contents unchanged.
- Full FIFO, `wr_en` and `rd_en` together -> read accepted, write rejected, count=7, `overflow`=1. Empty FIFO, both together -> count=1, `underflow`=1, `dout_valid` stays 0.
- Pointer wrap: push and pop 20 sequential values 0..19 with count kept ≤3 -> every value is read back in order with none lost; `err_clr` then returns both sticky flags to 0.
- `rst` raised asynchronously between clock edges with count=5 -> count=0, `empty`=1, and all flags at their reset values before the next edge.
- With `FIFO_FWFT_EN` defined: write 0xABCD into the empty FIFO -> `dout`=0xABCD and `dout_valid`=1 the next cycle with no `rd_en`; one `rd_en` -> `empty`=1 and `dout_valid`=0.
